// File: rtl/spare_mon_pkg.sv
// Shared definitions for the spare-cell tie-low monitor: register offsets,
// CTRL bit positions, bus FSM states and a byte-select expansion helper.
package spare_mon_pkg;

  localparam logic [4:0] OFF_STATUS = 5'h00;
  localparam logic [4:0] OFF_STICKY = 5'h04;
  localparam logic [4:0] OFF_COUNT  = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;
  localparam logic [4:0] OFF_MASK   = 5'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/spare_sync2.sv
// Parameterised-width two-flop synchroniser for lines asynchronous to i_clk.
module spare_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking assignments make both stages sample together, so the
  // chain really is two flops deep rather than collapsing into one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spare_tie_monitor.sv
// Watches spare-cell tie-low lines, latches any rising edge as a sticky flag,
// counts event cycles and exposes status on a Wishbone slave with a level irq.
module spare_tie_monitor
  import spare_mon_pkg::*;
#(
  parameter int          NUM_SPARE = 4,
  parameter int          CNT_W     = 8,
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NUM_SPARE-1:0] spare_lo_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic [31:0]          wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_SPARE-1:0] w_sync;
  logic [NUM_SPARE-1:0] w_ev;
  logic [NUM_SPARE-1:0] r_prev;
  logic [NUM_SPARE-1:0] r_sticky;
  logic [NUM_SPARE-1:0] r_mask;
  logic [CNT_W-1:0]     r_count;
  logic [1:0]           r_ctrl;
  logic                 r_irq;
  bus_state_t           r_state;
  logic                 r_ack;
  logic [31:0]          r_dat;

  logic                 w_hit;
  logic                 w_req;
  logic                 w_wr;
  logic [4:0]           w_off;
  logic [31:0]          w_wmask;
  logic [31:0]          w_rdata;
  logic [NUM_SPARE-1:0] w_sticky_clr;
  logic                 w_any_ev;

  spare_sync2 #(.WIDTH(NUM_SPARE)) u_sync (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_d   (spare_lo_i),
    .o_q   (w_sync)
  );

  assign w_ev     = {NUM_SPARE{r_ctrl[CTRL_EN]}} & r_mask & w_sync & ~r_prev;
  assign w_any_ev = |w_ev;

  assign w_hit   = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign w_req   = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
  assign w_wr    = w_req & wbs_we_i;
  assign w_off   = {wbs_adr_i[4:2], 2'b00};
  assign w_wmask = byte_mask(wbs_sel_i);

  assign w_sticky_clr = (w_wr && w_off == OFF_STICKY)
                      ? (wbs_dat_i[NUM_SPARE-1:0] & w_wmask[NUM_SPARE-1:0])
                      : '0;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_STATUS: w_rdata[NUM_SPARE-1:0] = w_sync;
      OFF_STICKY: w_rdata[NUM_SPARE-1:0] = r_sticky;
      OFF_COUNT:  w_rdata[CNT_W-1:0]     = r_count;
      OFF_CTRL:   w_rdata[1:0]           = r_ctrl;
      OFF_MASK:   w_rdata[NUM_SPARE-1:0] = r_mask;
      default:    w_rdata = '0;
    endcase
  end

  // Status registers; the edge detector's prev follows sync even while disabled,
  // so re-enabling never replays an edge that happened during the gap.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_prev   <= '0;
      r_sticky <= '0;
      r_count  <= '0;
      r_ctrl   <= '0;
      r_mask   <= '1;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= w_sync;
      r_sticky <= (r_sticky & ~w_sticky_clr) | w_ev;
      r_irq    <= r_ctrl[CTRL_IRQ_EN] & (|r_sticky);

      if (w_wr && w_off == OFF_COUNT)
        r_count <= w_any_ev ? CNT_W'(1) : '0;
      else if (w_any_ev && r_count != CNT_MAX)
        r_count <= r_count + CNT_W'(1);

      if (w_wr && w_off == OFF_CTRL && wbs_sel_i[0])
        r_ctrl <= wbs_dat_i[1:0];

      if (w_wr && w_off == OFF_MASK)
        r_mask <= (r_mask & ~w_wmask[NUM_SPARE-1:0])
                | (wbs_dat_i[NUM_SPARE-1:0] & w_wmask[NUM_SPARE-1:0]);
    end
  end

  // Bus FSM: one request, one acknowledge cycle, then back to idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= BUS_IDLE;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      case (r_state)
        BUS_IDLE: begin
          if (w_req) begin
            r_state <= BUS_ACK;
            r_ack   <= 1'b1;
            r_dat   <= wbs_we_i ? '0 : w_rdata;
          end else begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
          end
        end
        default: begin
          r_state <= BUS_IDLE;
          r_ack   <= 1'b0;
          r_dat   <= '0;
        end
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_spare_tie_monitor.sv
// Directed bench for spare_tie_monitor: register tables plus timed edge sequences.
module tb_spare_tie_monitor;

  localparam int          NUM_SPARE = 4;
  localparam int          CNT_W     = 2;
  localparam logic [31:0] BASE      = 32'h3000_0000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_SPARE-1:0] lo  = '0;
  logic                 cyc = 1'b0;
  logic                 stb = 1'b0;
  logic                 we  = 1'b0;
  logic [3:0]           sel = 4'h0;
  logic [31:0]          adr = '0;
  logic [31:0]          wdat = '0;
  logic [31:0]          rdat;
  logic                 ack;
  logic                 irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] off;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  spare_tie_monitor #(
    .NUM_SPARE (NUM_SPARE),
    .CNT_W     (CNT_W),
    .BASE_ADR  (BASE)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .spare_lo_i (lo),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_dat_o  (rdat),
    .wbs_ack_o  (ack),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0;
    rd    = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        acked = 1'b1;
        rd    = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input string name, input logic [31:0] off, input logic [31:0] d);
    logic [31:0] rd;
    logic        acked;
    wb_xfer(1'b1, BASE + off, d, 4'hF, rd, acked);
    check({name, " ack"}, {31'd0, acked}, 32'd1);
  endtask

  task automatic wb_read(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic        acked;
    wb_xfer(1'b0, BASE + off, '0, 4'hF, rd, acked);
    check({name, " ack"}, {31'd0, acked}, 32'd1);
    check(name, rd, exp);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        logic [31:0] rd;
        logic        acked;
        wb_xfer(1'b1, BASE + vecs[i].off, vecs[i].wdat, vecs[i].sel, rd, acked);
        check({vecs[i].name, " ack"}, {31'd0, acked}, 32'd1);
      end else begin
        wb_read(vecs[i].name, vecs[i].off, vecs[i].exp);
      end
    end
    vecs.delete();
  endtask

  task automatic load_reset_table();
    vecs.push_back('{"STATUS rst", 1'b0, 32'h00, 32'h0, 4'hF, 32'h0});
    vecs.push_back('{"STICKY rst", 1'b0, 32'h04, 32'h0, 4'hF, 32'h0});
    vecs.push_back('{"COUNT rst",  1'b0, 32'h08, 32'h0, 4'hF, 32'h0});
    vecs.push_back('{"CTRL rst",   1'b0, 32'h0C, 32'h0, 4'hF, 32'h0});
    vecs.push_back('{"MASK rst",   1'b0, 32'h10, 32'h0, 4'hF, 32'hF});
    vecs.push_back('{"MASK nosel", 1'b1, 32'h10, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{"MASK keep",  1'b0, 32'h10, 32'h0, 4'hF, 32'hF});
    vecs.push_back('{"UNMAPPED",   1'b0, 32'h14, 32'h0, 4'hF, 32'h0});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Raise a line and issue a write whose request lands on the event cycle.
  task automatic write_on_event(input string name, input int line,
                                input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    lo[line] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + off; wdat = d; sel = 4'hF;
    @(posedge clk);
    #1;
    check({name, " ack"}, {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    lo[line] = 1'b0;
    wait_cycles(4);
  endtask

  initial begin
    logic [31:0] rd;
    logic        acked;

    // 1: reset values
    wait_cycles(3);
    @(negedge clk);
    rst = 1'b0;
    load_reset_table();
    run_vecs();
    check("irq rst", {31'd0, irq}, 32'd0);

    // 2: single edge latency and irq timing
    wb_write("CTRL=3", 32'h0C, 32'h3);
    @(negedge clk);
    lo[2] = 1'b1;
    wait_cycles(3);
    #1 check("irq edge+3", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 check("irq edge+4", {31'd0, irq}, 32'd1);
    @(negedge clk);
    lo[2] = 1'b0;
    wait_cycles(4);
    wb_read("STICKY t2", 32'h04, 32'h4);
    wb_read("COUNT t2",  32'h08, 32'h1);

    // 3: two lines in one cycle, partial W1C
    wb_write("STICKY clr4", 32'h04, 32'h4);
    wait_cycles(2);
    #1 check("irq cleared", {31'd0, irq}, 32'd0);
    @(negedge clk);
    lo = 4'b1001;
    wait_cycles(5);
    wb_read("STATUS t3", 32'h00, 32'h9);
    wb_read("STICKY t3", 32'h04, 32'h9);
    wb_read("COUNT t3",  32'h08, 32'h2);
    wb_write("STICKY clr1", 32'h04, 32'h1);
    wb_read("STICKY after W1C", 32'h04, 32'h8);
    wait_cycles(2);
    #1 check("irq stays", {31'd0, irq}, 32'd1);
    @(negedge clk);
    lo = '0;
    wait_cycles(4);

    // 4: saturation, clear+increment, set beats clear
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lo[1] = 1'b1;
      wait_cycles(4);
      @(negedge clk);
      lo[1] = 1'b0;
      wait_cycles(4);
    end
    wb_read("COUNT sat", 32'h08, 32'h3);
    write_on_event("COUNT clr+ev", 1, 32'h08, 32'h0);
    wb_read("COUNT clr+ev", 32'h08, 32'h1);
    wb_write("STICKY clrall", 32'h04, 32'hF);
    wb_read("STICKY empty", 32'h04, 32'h0);
    write_on_event("STICKY set+clr", 1, 32'h04, 32'h2);
    wb_read("STICKY set wins", 32'h04, 32'h2);

    // 5: mask and disable
    wb_write("STICKY clr", 32'h04, 32'hF);
    wb_write("COUNT clr",  32'h08, 32'h0);
    wb_read("COUNT zero",  32'h08, 32'h0);
    wb_write("MASK=E", 32'h10, 32'hE);
    @(negedge clk);
    lo[0] = 1'b1;
    wait_cycles(5);
    wb_read("STICKY masked", 32'h04, 32'h0);
    wb_read("COUNT masked",  32'h08, 32'h0);
    wb_read("STATUS masked", 32'h00, 32'h1);
    @(negedge clk);
    lo[0] = 1'b0;
    wb_write("CTRL=2", 32'h0C, 32'h2);
    @(negedge clk);
    lo[2] = 1'b1;
    wait_cycles(5);
    wb_read("STATUS disabled", 32'h00, 32'h4);
    wb_read("STICKY disabled", 32'h04, 32'h0);
    wb_read("COUNT disabled",  32'h08, 32'h0);
    wb_write("CTRL=3 again", 32'h0C, 32'h3);
    wait_cycles(4);
    wb_read("STICKY no replay", 32'h04, 32'h0);
    wb_read("COUNT no replay",  32'h08, 32'h0);
    @(negedge clk);
    lo = '0;

    // out-of-window access gets no ack
    wb_xfer(1'b0, BASE + 32'h20, '0, 4'hF, rd, acked);
    check("outside no ack", {31'd0, acked}, 32'd0);

    // 6: reset during an acknowledge
    wb_write("MASK=3", 32'h10, 32'h3);
    wait_cycles(4);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    @(posedge clk);
    #1 check("ack before rst", {31'd0, ack}, 32'd1);
    rst = 1'b1;
    #1 check("ack dropped", {31'd0, ack}, 32'd0);
    check("irq in rst", {31'd0, irq}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    wait_cycles(2);
    @(negedge clk);
    rst = 1'b0;
    load_reset_table();
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
